// File: rtl/frame_buf_ctrl.sv
// rtl/frame_buf_ctrl.sv - double-buffer scheduler for the UART->SDRAM->VGA frame path
//
// Gates UART pixel strobes into the SDRAM back buffer, counts accepted pixels,
// and on frame completion waits for VGA frame start before swapping the
// front/back buffers and pulsing the FIFO resets.
//
// Ports:
//   sys_clk, sys_rst_n          clock, asynchronous active-low reset
//   init_end                    SDRAM init complete (level); low forces IDLE
//   wr_pix_flag                 one-clock pixel strobe from uart_rx
//   frame_start                 one-clock VGA frame start pulse
//   wr_req_o                    gated write request (combinational)
//   wr_b_addr/wr_e_addr         write burst begin/end address
//   rd_b_addr/rd_e_addr         read burst begin/end address
//   wr_rst/rd_rst               FIFO/address clears, high for RST_PULSE clocks
//   read_valid                  SDRAM read enable, sticky after the first swap
//   frame_done                  one-clock pulse after the last pixel of a frame
//   frame_cnt                   swap count, wraps at 256
//   drop_cnt                    pixels dropped while swapping, saturating

module frame_buf_ctrl #(
    parameter logic [23:0] FRAME_PIX = 24'd307200,
    parameter logic [23:0] BUF0_BASE = 24'd0,
    parameter logic [23:0] BUF1_BASE = 24'd524288,
    parameter int          RST_PULSE = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        init_end,
    input  logic        wr_pix_flag,
    input  logic        frame_start,
    output logic        wr_req_o,
    output logic [23:0] wr_b_addr,
    output logic [23:0] wr_e_addr,
    output logic [23:0] rd_b_addr,
    output logic [23:0] rd_e_addr,
    output logic        wr_rst,
    output logic        rd_rst,
    output logic        read_valid,
    output logic        frame_done,
    output logic [7:0]  frame_cnt,
    output logic [15:0] drop_cnt
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FILL      = 2'd1,
        SWAP_WAIT = 2'd2,
        SWAP      = 2'd3
    } state_t;

    // Reset counter is loaded with RST_PULSE-1 on SWAP entry; the entry clock
    // itself is the first of the RST_PULSE clocks with the resets high.
    localparam logic [3:0] RST_LAST = 4'(RST_PULSE - 1);

    state_t      state_q;
    logic        wr_sel_q;
    logic        rd_sel_q;
    logic [23:0] pix_cnt_q;
    logic [3:0]  rst_cnt_q;
    logic [23:0] wr_b_addr_q;
    logic [23:0] wr_e_addr_q;
    logic [23:0] rd_b_addr_q;
    logic [23:0] rd_e_addr_q;
    logic        wr_rst_q;
    logic        rd_rst_q;
    logic        read_valid_q;
    logic        frame_done_q;
    logic [7:0]  frame_cnt_q;
    logic [15:0] drop_cnt_q;

    // Kept combinational so the request lines up with the UART data byte.
    assign wr_req_o = wr_pix_flag & (state_q == FILL);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= IDLE;
            wr_sel_q     <= 1'b0;
            rd_sel_q     <= 1'b1;
            pix_cnt_q    <= '0;
            rst_cnt_q    <= '0;
            wr_b_addr_q  <= BUF0_BASE;
            wr_e_addr_q  <= BUF0_BASE + FRAME_PIX;
            rd_b_addr_q  <= BUF1_BASE;
            rd_e_addr_q  <= BUF1_BASE + FRAME_PIX;
            wr_rst_q     <= 1'b0;
            rd_rst_q     <= 1'b0;
            read_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
            drop_cnt_q   <= '0;
        end else begin
            frame_done_q <= 1'b0;
            if (!init_end) begin
                // Losing SDRAM init abandons the frame but keeps buffer
                // assignment and statistics.
                state_q   <= IDLE;
                pix_cnt_q <= '0;
                rst_cnt_q <= '0;
                wr_rst_q  <= 1'b0;
                rd_rst_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= FILL;
                    end
                    FILL: begin
                        // frame_start is deliberately ignored here, including
                        // in the clock that accepts the last pixel.
                        if (wr_pix_flag) begin
                            if (pix_cnt_q == FRAME_PIX - 24'd1) begin
                                pix_cnt_q    <= '0;
                                frame_done_q <= 1'b1;
                                state_q      <= SWAP_WAIT;
                            end else begin
                                pix_cnt_q <= pix_cnt_q + 24'd1;
                            end
                        end
                    end
                    SWAP_WAIT: begin
                        if (wr_pix_flag && drop_cnt_q != 16'hFFFF) begin
                            drop_cnt_q <= drop_cnt_q + 16'd1;
                        end
                        if (frame_start) begin
                            state_q      <= SWAP;
                            wr_sel_q     <= ~wr_sel_q;
                            rd_sel_q     <= ~rd_sel_q;
                            // Addresses follow the new (toggled) selects.
                            wr_b_addr_q  <= wr_sel_q ? BUF0_BASE : BUF1_BASE;
                            wr_e_addr_q  <= wr_sel_q ? BUF0_BASE + FRAME_PIX
                                                     : BUF1_BASE + FRAME_PIX;
                            rd_b_addr_q  <= rd_sel_q ? BUF0_BASE : BUF1_BASE;
                            rd_e_addr_q  <= rd_sel_q ? BUF0_BASE + FRAME_PIX
                                                     : BUF1_BASE + FRAME_PIX;
                            frame_cnt_q  <= frame_cnt_q + 8'd1;
                            read_valid_q <= 1'b1;
                            wr_rst_q     <= 1'b1;
                            rd_rst_q     <= 1'b1;
                            rst_cnt_q    <= RST_LAST;
                        end
                    end
                    SWAP: begin
                        if (wr_pix_flag && drop_cnt_q != 16'hFFFF) begin
                            drop_cnt_q <= drop_cnt_q + 16'd1;
                        end
                        if (rst_cnt_q == 4'd0) begin
                            state_q  <= FILL;
                            wr_rst_q <= 1'b0;
                            rd_rst_q <= 1'b0;
                        end else begin
                            rst_cnt_q <= rst_cnt_q - 4'd1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign wr_b_addr  = wr_b_addr_q;
    assign wr_e_addr  = wr_e_addr_q;
    assign rd_b_addr  = rd_b_addr_q;
    assign rd_e_addr  = rd_e_addr_q;
    assign wr_rst     = wr_rst_q;
    assign rd_rst     = rd_rst_q;
    assign read_valid = read_valid_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_frame_buf_ctrl.sv
// tb/tb_frame_buf_ctrl.sv - randomized self-checking bench for frame_buf_ctrl

module tb_frame_buf_ctrl;

    localparam logic [23:0] FP = 24'd16;
    localparam logic [23:0] B0 = 24'd0;
    localparam logic [23:0] B1 = 24'd524288;
    localparam int          RP = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ie = 1'b0;
    logic        pf = 1'b0;
    logic        fs = 1'b0;
    logic        wr_req_o;
    logic [23:0] wr_b_addr, wr_e_addr, rd_b_addr, rd_e_addr;
    logic        wr_rst, rd_rst, read_valid, frame_done;
    logic [7:0]  frame_cnt;
    logic [15:0] drop_cnt;

    frame_buf_ctrl #(
        .FRAME_PIX(FP),
        .BUF0_BASE(B0),
        .BUF1_BASE(B1),
        .RST_PULSE(RP)
    ) dut (
        .sys_clk    (clk),
        .sys_rst_n  (rst_n),
        .init_end   (ie),
        .wr_pix_flag(pf),
        .frame_start(fs),
        .wr_req_o   (wr_req_o),
        .wr_b_addr  (wr_b_addr),
        .wr_e_addr  (wr_e_addr),
        .rd_b_addr  (rd_b_addr),
        .rd_e_addr  (rd_e_addr),
        .wr_rst     (wr_rst),
        .rd_rst     (rd_rst),
        .read_valid (read_valid),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: what the frame path is doing, in plain terms.
    bit m_filling;      // accepting pixels into the back buffer
    bit m_waiting;      // frame complete, waiting for VGA frame start
    int m_rst_left;     // clocks of FIFO reset still to show (swap in progress)
    int m_pix;          // pixels accepted in the current frame
    int m_swaps;        // total swaps since reset
    bit m_back_is_1;    // back (write) buffer is buffer 1
    bit m_reading;      // at least one swap has happened
    bit m_done;         // frame_done expected this clock
    int m_drop;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_filling = 0; m_waiting = 0; m_rst_left = 0; m_pix = 0; m_swaps = 0;
        m_back_is_1 = 0; m_reading = 0; m_done = 0; m_drop = 0;
    endtask

    task automatic model_clock(input bit p, input bit f, input bit e);
        m_done = 0;
        if (!e) begin
            m_filling = 0; m_waiting = 0; m_rst_left = 0; m_pix = 0;
        end else if (m_filling) begin
            if (p) begin
                m_pix++;
                if (m_pix == int'(FP)) begin
                    m_pix = 0; m_filling = 0; m_waiting = 1; m_done = 1;
                end
            end
        end else if (m_waiting) begin
            if (p && m_drop < 65535) m_drop++;
            if (f) begin
                m_waiting = 0; m_rst_left = RP; m_back_is_1 = !m_back_is_1;
                m_swaps++; m_reading = 1;
            end
        end else if (m_rst_left > 0) begin
            if (p && m_drop < 65535) m_drop++;
            m_rst_left--;
            if (m_rst_left == 0) m_filling = 1;
        end else begin
            m_filling = 1;
        end
    endtask

    task automatic check_outputs();
        logic [23:0] wb, rb;
        wb = m_back_is_1 ? B1 : B0;
        rb = m_back_is_1 ? B0 : B1;
        chk("wr_b_addr", 32'(wr_b_addr), 32'(wb));
        chk("wr_e_addr", 32'(wr_e_addr), 32'(wb) + 32'(FP));
        chk("rd_b_addr", 32'(rd_b_addr), 32'(rb));
        chk("rd_e_addr", 32'(rd_e_addr), 32'(rb) + 32'(FP));
        chk("wr_rst", 32'(wr_rst), 32'(m_rst_left > 0));
        chk("rd_rst", 32'(rd_rst), 32'(m_rst_left > 0));
        chk("read_valid", 32'(read_valid), 32'(m_reading));
        chk("frame_done", 32'(frame_done), 32'(m_done));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_swaps % 256));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    endtask

    task automatic step(input bit p, input bit f, input bit e);
        @(negedge clk);
        pf = p; fs = f; ie = e;
        #1;
        chk("wr_req_o", 32'(wr_req_o), 32'(p && m_filling));
        @(posedge clk);
        model_clock(p, f, e);
        #1;
        check_outputs();
    endtask

    initial begin
        int target;
        int budget;
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        chk("reset_wr_req", 32'(wr_req_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // No SDRAM init: strobes never pass.
        repeat (5) step(1, 0, 0);
        step(0, 0, 0);

        // One frame of 16 pixels, then drops while waiting.
        step(0, 0, 1);
        repeat (16) step(1, 0, 1);
        chk("frame_done_16th", 32'(frame_done), 32'd1);
        repeat (3) step(1, 0, 1);
        chk("drop_3", 32'(drop_cnt), 32'd3);

        // Swap.
        step(0, 1, 1);
        chk("swap_wr_b", 32'(wr_b_addr), 32'(B1));
        chk("swap_rd_b", 32'(rd_b_addr), 32'(B0));
        repeat (RP) step(0, 0, 1);

        // Last pixel together with frame_start: no swap until the next one.
        repeat (15) step(1, 0, 1);
        step(1, 1, 1);
        chk("no_swap_same_clk", 32'(wr_rst), 32'd0);
        repeat (9) step(0, 0, 1);
        step(0, 1, 1);
        chk("late_swap", 32'(frame_cnt), 32'd2);
        repeat (RP) step(0, 0, 1);

        // init_end drop mid-frame restarts the pixel count.
        repeat (7) step(1, 0, 1);
        step(0, 0, 0);
        step(0, 0, 1);
        repeat (15) step(1, 0, 1);
        chk("restart_not_done", 32'(frame_done), 32'd0);
        step(1, 0, 1);
        chk("restart_done", 32'(frame_done), 32'd1);
        step(0, 1, 1);
        repeat (RP) step(0, 0, 1);

        // 257 random frames.
        target = m_swaps + 257;
        budget = 40000;
        while (m_swaps < target && budget > 0) begin
            step(1'($urandom % 2), 1'($urandom % 8 == 0), 1'b1);
            budget--;
        end
        chk("frames_budget", 32'(budget > 0), 32'd1);
        chk("frame_cnt_wrap", 32'(frame_cnt), 32'(target % 256));

        // Async reset in the middle of a swap.
        budget = 2000;
        while (m_rst_left == 0 && budget > 0) begin
            step(1'($urandom % 2), 1'($urandom % 4 == 0), 1'b1);
            budget--;
        end
        chk("swap_budget", 32'(budget > 0), 32'd1);
        step(0, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_wr_rst", 32'(wr_rst), 32'd0);
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 1);
        repeat (20) step(1'($urandom % 2), 1'($urandom % 8 == 0), 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
